// File: rtl/cpu_sequencer.sv
// Microcoded-style instruction sequencer: FETCH/EXEC/HALT control FSM
// that owns pc and ir and emits the datapath control word.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dbus,
    input  logic        mem_wait,
    input  logic        flag_c,
    input  logic        flag_z,
    input  logic        resume,
    output logic [14:0] ctrl,
    output logic [7:0]  pc,
    output logic [7:0]  ir,
    output logic        halted
);

    localparam int LOAD_IR   = 14;
    localparam int LOAD_PC   = 13;
    localparam int LOAD_A    = 12;
    localparam int LOAD_B    = 11;
    localparam int LOAD_X    = 10;
    localparam int DO_OUT    = 9;
    localparam int STORE_MEM = 8;
    localparam int ASSERT_M  = 7;
    localparam int ASSERT_E  = 6;
    localparam int ASSERT_A  = 5;
    localparam int ASSERT_X  = 4;
    localparam int IMMED     = 3;
    localparam int JUMP_CTL  = 2;
    localparam int DO_SUB    = 1;
    localparam int DO_JUMP   = 0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [14:0] ctrl_c;
    logic        jump_c;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ctrl_c  = '0;
        jump_c  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (!mem_wait) begin
                    ctrl_c[LOAD_IR]  = 1'b1;
                    ctrl_c[ASSERT_M] = 1'b1;
                    ir_d    = dbus;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!mem_wait) begin
                    unique case (ir_q[3:2])
                        2'd0: ctrl_c[ASSERT_M] = 1'b1;
                        2'd1: ctrl_c[ASSERT_E] = 1'b1;
                        2'd2: ctrl_c[ASSERT_A] = 1'b1;
                        2'd3: ctrl_c[ASSERT_X] = 1'b1;
                        default: ;
                    endcase
                    ctrl_c[IMMED]  = ir_q[7];
                    ctrl_c[DO_SUB] = ir_q[1];
                    unique case (ir_q[6:4])
                        3'd0: ctrl_c[LOAD_A]    = 1'b1;
                        3'd1: ctrl_c[LOAD_B]    = 1'b1;
                        3'd2: ctrl_c[LOAD_X]    = 1'b1;
                        3'd3: ctrl_c[DO_OUT]    = 1'b1;
                        3'd4: ctrl_c[STORE_MEM] = 1'b1;
                        3'd5: begin
                            ctrl_c[LOAD_PC] = 1'b1;
                            jump_c          = 1'b1;
                        end
                        3'd6: begin
                            ctrl_c[LOAD_PC]  = 1'b1;
                            ctrl_c[JUMP_CTL] = 1'b1;
                            jump_c           = flag_c;
                        end
                        3'd7: begin
                            ctrl_c[LOAD_PC]  = 1'b1;
                            ctrl_c[JUMP_CTL] = 1'b1;
                            jump_c           = flag_z;
                        end
                        default: ;
                    endcase
                    ctrl_c[DO_JUMP] = jump_c;
                    // Immediate operands sit at pc; skip past them unless jumping.
                    if (jump_c) begin
                        pc_d = dbus;
                    end else if (ir_q[7]) begin
                        pc_d = pc_q + 8'd1;
                    end
                    state_d = ir_q[0] ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign ctrl   = reset ? 15'd0 : ctrl_c;
    assign pc     = pc_q;
    assign ir     = ir_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer: expected ctrl and
// post-edge {halted, ir, pc} are queued at drive time and checked in order.
module tb_cpu_sequencer;

    localparam logic [14:0] LIR  = 15'h4000;
    localparam logic [14:0] LPC  = 15'h2000;
    localparam logic [14:0] LA   = 15'h1000;
    localparam logic [14:0] DOUT = 15'h0200;
    localparam logic [14:0] AM   = 15'h0080;
    localparam logic [14:0] AE   = 15'h0040;
    localparam logic [14:0] AA   = 15'h0020;
    localparam logic [14:0] AX   = 15'h0010;
    localparam logic [14:0] IMM  = 15'h0008;
    localparam logic [14:0] JC   = 15'h0004;
    localparam logic [14:0] SUB  = 15'h0002;
    localparam logic [14:0] DJ   = 15'h0001;
    localparam logic [14:0] FW   = LIR | AM;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dbus;
    logic        mem_wait;
    logic        flag_c;
    logic        flag_z;
    logic        resume;
    logic [14:0] ctrl;
    logic [7:0]  pc;
    logic [7:0]  ir;
    logic        halted;

    int tests = 0;
    int fails = 0;

    logic [14:0] exp_ctrl_q[$];
    logic [16:0] exp_st_q[$];

    cpu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .dbus     (dbus),
        .mem_wait (mem_wait),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .resume   (resume),
        .ctrl     (ctrl),
        .pc       (pc),
        .ir       (ir),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, check ctrl, then check state after the edge.
    task automatic cyc(input string tag, input logic rst, input logic [7:0] d,
                       input logic mw, input logic fc, input logic fz,
                       input logic rs, input logic [14:0] e_ctrl,
                       input logic [7:0] e_pc, input logic [7:0] e_ir,
                       input logic e_halt);
        logic [14:0] ec;
        logic [16:0] es;
        @(negedge clk);
        reset    = rst;
        dbus     = d;
        mem_wait = mw;
        flag_c   = fc;
        flag_z   = fz;
        resume   = rs;
        exp_ctrl_q.push_back(e_ctrl);
        exp_st_q.push_back({e_halt, e_ir, e_pc});
        #1;
        ec = exp_ctrl_q.pop_front();
        tests++;
        assert (ctrl === ec) else begin
            fails++;
            $error("FAIL %s ctrl: got %h expected %h", tag, ctrl, ec);
        end
        @(posedge clk);
        #1;
        es = exp_st_q.pop_front();
        tests++;
        assert ({halted, ir, pc} === es) else begin
            fails++;
            $error("FAIL %s state: got h=%b ir=%h pc=%h expected h=%b ir=%h pc=%h",
                   tag, halted, ir, pc, es[16], es[15:8], es[7:0]);
        end
    endtask

    initial begin
        reset = 1'b1; dbus = 8'h00; mem_wait = 1'b0;
        flag_c = 1'b0; flag_z = 1'b0; resume = 1'b0;
        //   tag            rst d      mw fc fz rs ctrl                 pc     ir     h
        cyc("reset0",       1, 8'h55, 0, 0, 0, 0, 15'd0,               8'h00, 8'h00, 0);
        cyc("reset1",       1, 8'h55, 1, 0, 0, 1, 15'd0,               8'h00, 8'h00, 0);
        cyc("fetch_imm",    0, 8'h80, 0, 0, 0, 0, FW,                  8'h01, 8'h80, 0);
        cyc("exec_imm",     0, 8'h12, 0, 0, 0, 0, LA | AM | IMM,       8'h02, 8'h80, 0);
        cyc("fetch_jz",     0, 8'h74, 0, 0, 0, 0, FW,                  8'h03, 8'h74, 0);
        cyc("jz_nottaken",  0, 8'h40, 0, 1, 0, 0, LPC | AE | JC,       8'h03, 8'h74, 0);
        cyc("fetch_jz2",    0, 8'h74, 0, 0, 0, 0, FW,                  8'h04, 8'h74, 0);
        cyc("jz_taken",     0, 8'h40, 0, 0, 1, 0, LPC | AE | JC | DJ,  8'h40, 8'h74, 0);
        cyc("fetch_jc",     0, 8'h6C, 0, 0, 0, 0, FW,                  8'h41, 8'h6C, 0);
        cyc("jc_taken",     0, 8'hFF, 0, 1, 0, 0, LPC | AX | JC | DJ,  8'hFF, 8'h6C, 0);
        cyc("fetch_wrap",   0, 8'h50, 0, 0, 0, 0, FW,                  8'h00, 8'h50, 0);
        cyc("wait_e1",      0, 8'h20, 1, 0, 0, 0, 15'd0,               8'h00, 8'h50, 0);
        cyc("wait_e2",      0, 8'h20, 1, 0, 0, 0, 15'd0,               8'h00, 8'h50, 0);
        cyc("wait_e3",      0, 8'h20, 1, 0, 0, 0, 15'd0,               8'h00, 8'h50, 0);
        cyc("jmp_after_w",  0, 8'h20, 0, 0, 0, 0, LPC | AM | DJ,       8'h20, 8'h50, 0);
        cyc("fetch_self",   0, 8'h50, 0, 0, 0, 0, FW,                  8'h21, 8'h50, 0);
        cyc("jmp_self",     0, 8'h20, 0, 0, 0, 0, LPC | AM | DJ,       8'h20, 8'h50, 0);
        cyc("fetch_halt",   0, 8'h39, 0, 0, 0, 0, FW,                  8'h21, 8'h39, 0);
        cyc("exec_out",     0, 8'hAA, 0, 0, 0, 0, DOUT | AA,           8'h21, 8'h39, 1);
        cyc("halt_wait",    0, 8'hAA, 1, 1, 1, 0, 15'd0,               8'h21, 8'h39, 1);
        cyc("halt_resume",  0, 8'hAA, 0, 0, 0, 1, 15'd0,               8'h21, 8'h39, 0);
        cyc("fetch_resume", 0, 8'h52, 0, 0, 0, 0, FW,                  8'h22, 8'h52, 0);
        cyc("reset_exec",   1, 8'h55, 1, 0, 0, 1, 15'd0,               8'h00, 8'h00, 0);
        cyc("fetch_post",   0, 8'h90, 0, 0, 0, 0, FW,                  8'h01, 8'h90, 0);
        cyc("exec_sub_b",   0, 8'h07, 0, 0, 0, 0, 15'h0800 | AM | IMM, 8'h02, 8'h90, 0);
        cyc("fetch_fw",     0, 8'h0A, 1, 0, 0, 0, 15'd0,               8'h02, 8'h90, 0);
        cyc("fetch_sub",    0, 8'h0A, 0, 0, 0, 0, FW,                  8'h03, 8'h0A, 0);
        cyc("exec_sub",     0, 8'h00, 0, 0, 0, 0, LA | AA | SUB,       8'h03, 8'h0A, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
